// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single 4-bit add slice, LSB nibble first.
// Define NIBBLE_ADDER_SUB_EN to add an i_sub port that turns the operation into a - b.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inValid,
  output logic             o_inReady,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef NIBBLE_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_outValid,
  input  logic             i_outReady,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  generate
    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_badWidth
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_aQ;
  logic [WIDTH-1:0] r_bQ;
  logic [WIDTH-1:0] r_sum;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             w_accept;
  logic             w_lastNib;
  logic [3:0]       w_aNib;
  logic [3:0]       w_bNib;
  logic [4:0]       w_addRes;
  logic [WIDTH-1:0] w_bLoad;
  logic             w_carryLoad;

  assign w_accept  = (r_state == IDLE) && i_inValid;
  assign w_lastNib = (r_idx == LAST_IDX);

`ifdef NIBBLE_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the latched carry replaces cin.
  assign w_bLoad     = i_sub ? ~i_b : i_b;
  assign w_carryLoad = i_sub ? 1'b1 : i_cin;
`else
  assign w_bLoad     = i_b;
  assign w_carryLoad = i_cin;
`endif

  always_comb begin
    w_aNib = '0;
    w_bNib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (r_idx == IDXW'(n)) begin
        w_aNib = r_aQ[4*n +: 4];
        w_bNib = r_bQ[4*n +: 4];
      end
    end
  end

  assign w_addRes = {1'b0, w_aNib} + {1'b0, w_bNib} + {4'b0000, r_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (i_inValid)  w_stateNext = RUN;
      RUN:     if (w_lastNib)  w_stateNext = DONE;
      DONE:    if (i_outReady) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Operand latch and one nibble of the carry chain per clock while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aQ    <= '0;
      r_bQ    <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_aQ    <= i_a;
      r_bQ    <= w_bLoad;
      r_carry <= w_carryLoad;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      for (int n = 0; n < NIB; n++) begin
        if (r_idx == IDXW'(n)) begin
          r_sum[4*n +: 4] <= w_addRes[3:0];
        end
      end
      r_carry <= w_addRes[4];
      if (w_lastNib) begin
        r_cout <= w_addRes[4];
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign o_inReady  = (r_state == IDLE);
  assign o_outValid = (r_state == DONE);
  assign o_busy     = (r_state != IDLE);
  assign o_sum      = r_sum;
  assign o_cout     = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl: operands go in, expected {cout, sum} go into a queue,
// and each result is popped and compared when out_valid appears.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_inValid;
  logic             o_inReady;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
`ifdef NIBBLE_ADDER_SUB_EN
  logic             i_sub;
`endif
  logic             o_outValid;
  logic             i_outReady;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_busy;

  int nVectors     = 0;
  int nMiscompares = 0;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inValid  (i_inValid),
    .o_inReady  (o_inReady),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_cin      (i_cin),
`ifdef NIBBLE_ADDER_SUB_EN
    .i_sub      (i_sub),
`endif
    .o_outValid (o_outValid),
    .i_outReady (i_outReady),
    .o_sum      (o_sum),
    .o_cout     (o_cout),
    .o_busy     (o_busy)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents operands until accepted; the reference result is queued at the accept edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub, input bit push);
    int         waitCycles = 0;
    logic [WIDTH:0] total;
    logic [WIDTH-1:0] bInv;
    i_a       = a;
    i_b       = b;
    i_cin     = cin;
`ifdef NIBBLE_ADDER_SUB_EN
    i_sub     = sub;
`endif
    i_inValid = 1'b1;
    while (!o_inReady && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!o_inReady) begin
      checkValue("acceptTimeout", 32'(o_inReady), 32'd1);
      i_inValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    i_inValid = 1'b0;
    if (push) begin
      bInv = ~b;
      if (sub) total = {1'b0, a} + {1'b0, bInv} + {{WIDTH{1'b0}}, 1'b1};
      else     total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      expQ.push_back('{sum: total[WIDTH-1:0], cout: total[WIDTH]});
    end
  endtask

  // Waits for out_valid, checks latency and result, optionally stalls with in_valid pulses, then drains.
  task automatic checkOutput(input int holdCycles, input bit scramble);
    int   lat = 0;
    exp_t e;
    while (!o_outValid && lat < 20) begin
      if (scramble) begin
        i_a   = WIDTH'($urandom);
        i_b   = WIDTH'($urandom);
        i_cin = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    checkValue("latency", 32'(lat), 32'(NIB));
    if (!o_outValid) return;
    if (expQ.size() == 0) begin
      checkValue("unexpectedResult", 32'(o_outValid), 32'd0);
      return;
    end
    e = expQ.pop_front();
    checkValue("sum", 32'(o_sum), 32'(e.sum));
    checkValue("cout", 32'(o_cout), 32'(e.cout));
    for (int h = 0; h < holdCycles; h++) begin
      i_a       = WIDTH'($urandom);
      i_b       = WIDTH'($urandom);
      i_inValid = 1'b1;
      @(posedge clk); #1;
      i_inValid = 1'b0;
      checkValue("holdSum", 32'(o_sum), 32'(e.sum));
      checkValue("holdCout", 32'(o_cout), 32'(e.cout));
      checkValue("holdInReady", 32'(o_inReady), 32'd0);
      checkValue("holdOutValid", 32'(o_outValid), 32'd1);
    end
    i_outReady = 1'b1;
    @(posedge clk); #1;
    i_outReady = 1'b0;
    checkValue("retInReady", 32'(o_inReady), 32'd1);
    checkValue("retOutValid", 32'(o_outValid), 32'd0);
    checkValue("retBusy", 32'(o_busy), 32'd0);
    checkValue("keepSum", 32'(o_sum), 32'(e.sum));
  endtask

  initial begin
    rst_n      = 1'b0;
    i_inValid  = 1'b0;
    i_a        = '0;
    i_b        = '0;
    i_cin      = 1'b0;
`ifdef NIBBLE_ADDER_SUB_EN
    i_sub      = 1'b0;
`endif
    i_outReady = 1'b0;
    #12;
    checkValue("rstInReady", 32'(o_inReady), 32'd1);
    checkValue("rstOutValid", 32'(o_outValid), 32'd0);
    checkValue("rstBusy", 32'(o_busy), 32'd0);
    checkValue("rstSum", 32'(o_sum), 32'd0);
    checkValue("rstCout", 32'(o_cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    i_outReady = 1'b1;
    @(posedge clk); #1;
    i_outReady = 1'b0;
    checkValue("idleOutReadyIgnored", 32'(o_inReady), 32'd1);

    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
    checkOutput(0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    checkOutput(3, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    checkOutput(0, 1'b0);
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    checkOutput(0, 1'b1);

    // Reset in the second RUN cycle must discard the operation without a result.
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkValue("midRstOutValid", 32'(o_outValid), 32'd0);
    checkValue("midRstSum", 32'(o_sum), 32'd0);
    checkValue("midRstCout", 32'(o_cout), 32'd0);
    checkValue("midRstInReady", 32'(o_inReady), 32'd1);
    checkValue("midRstBusy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NIB + 1) @(posedge clk);
    #1;
    checkValue("postRstNoResult", 32'(o_outValid), 32'd0);
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1);
    checkOutput(0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 1'b1);
      checkOutput(k % 2, 1'b1);
    end

`ifdef NIBBLE_ADDER_SUB_EN
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    checkOutput(0, 1'b0);
    applyStimulus(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1);
    checkOutput(0, 1'b0);
    i_sub = 1'b0;
`endif

    checkValue("scoreboardDrain", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
